// File: rtl/pulse_stretcher_pkg.sv
// Shared definitions for the pulse stretcher: state encoding, sizing helpers
// and a parameter legality check.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // Number of bits needed to represent values 0..value-1 (0 for value <= 1).
  function automatic int clog2_f(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  function automatic int max_f(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // All three parameters must be at least one.
  function automatic bit params_legal(input int hold, input int gap, input int depth);
    return (hold >= 1) && (gap >= 1) && (depth >= 1);
  endfunction

endpackage

// File: rtl/pulse_stretcher_timer.sv
// Loadable down-counter shared by the low window and the high gap.
// The count parks at zero until the next load.
module stretch_timer
  import pulse_stretcher_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count_r;

  // Count register: load wins, otherwise decrement and stick at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != '0) begin
      count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Turns single-cycle active-high event pulses into fixed-length active-low
// windows separated by a mandatory high gap. Events arriving while a window
// or gap is running are queued in a saturating counter; excess events are
// dropped and flagged on Overflow.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 8,
  parameter int PEND_DEPTH  = 3
) (
  input  logic Clk,
  input  logic Reset,
  input  logic PulseIn,
  output logic LevelOut,
  output logic Busy,
  output logic Overflow
);

  // Timer width never collapses below one bit, even for 1-cycle windows.
  localparam int TMR_W = clog2_f(max_f(max_f(HOLD_CYCLES, GAP_CYCLES), 2));
  localparam int CNT_W = clog2_f(PEND_DEPTH + 1);

  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PEND_MAX  = CNT_W'(PEND_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  if (!params_legal(HOLD_CYCLES, GAP_CYCLES, PEND_DEPTH)) begin : g_bad_params
    $error("pulse_stretcher: HOLD_CYCLES, GAP_CYCLES and PEND_DEPTH must all be >= 1");
  end

  state_t           state_r;
  state_t           next_state_s;
  logic [CNT_W-1:0] pending_r;
  logic [CNT_W-1:0] next_pending_s;
  logic             load_s;
  logic [TMR_W-1:0] load_val_s;
  logic             drop_s;
  logic             timer_zero_s;
  logic             level_out_r;
  logic             busy_r;
  logic             overflow_r;

  stretch_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk      (Clk),
    .rst      (Reset),
    .load     (load_s),
    .load_val (load_val_s),
    .zero     (timer_zero_s)
  );

  // Next-state, timer-load and queue bookkeeping for the current cycle.
  always_comb begin
    next_state_s   = state_r;
    next_pending_s = pending_r;
    load_s         = 1'b0;
    load_val_s     = '0;
    drop_s         = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (PulseIn) begin
          next_state_s = S_HOLD;
          load_s       = 1'b1;
          load_val_s   = HOLD_LOAD;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_HOLD: begin
        if (timer_zero_s) begin
          next_state_s = S_GAP;
          load_s       = 1'b1;
          load_val_s   = GAP_LOAD;
        end else begin
          next_state_s = S_HOLD;
        end
        if (PulseIn) begin
          if (pending_r < PEND_MAX) begin
            next_pending_s = pending_r + CNT_ONE;
          end else begin
            drop_s = 1'b1;
          end
        end else begin
          next_pending_s = pending_r;
        end
      end
      S_GAP: begin
        if (timer_zero_s && ((pending_r != '0) || PulseIn)) begin
          // Back-to-back window: consume one queued event first; a
          // coincident pulse then refills the slot just freed.
          next_state_s = S_HOLD;
          load_s       = 1'b1;
          load_val_s   = HOLD_LOAD;
          if ((pending_r != '0) && !PulseIn) begin
            next_pending_s = pending_r - CNT_ONE;
          end else begin
            next_pending_s = pending_r;
          end
        end else if (timer_zero_s) begin
          next_state_s = S_IDLE;
        end else begin
          next_state_s = S_GAP;
          if (PulseIn) begin
            if (pending_r < PEND_MAX) begin
              next_pending_s = pending_r + CNT_ONE;
            end else begin
              drop_s = 1'b1;
            end
          end else begin
            next_pending_s = pending_r;
          end
        end
      end
      default: begin
        // Unreachable encoding: recover to idle with the queue flushed.
        next_state_s   = S_IDLE;
        next_pending_s = '0;
      end
    endcase
  end

  // State, queue and output registers; outputs follow the next state so
  // LevelOut drops on the same edge that accepts the pulse.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r     <= S_IDLE;
      pending_r   <= '0;
      level_out_r <= 1'b1;
      busy_r      <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      pending_r   <= next_pending_s;
      level_out_r <= (next_state_s != S_HOLD);
      busy_r      <= (next_state_s != S_IDLE) || (next_pending_s != '0);
      overflow_r  <= drop_s;
    end
  end

  assign LevelOut = level_out_r;
  assign Busy     = busy_r;
  assign Overflow = overflow_r;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher (HOLD=4, GAP=2, DEPTH=2). Expected
// per-edge output values are derived from the window/busy/overflow timing
// of each scenario and queued before the stimulus runs; each entry is
// popped and compared right after its edge.
module tb_pulse_stretcher;

  logic Clk = 1'b0;
  logic Reset;
  logic PulseIn;
  logic LevelOut;
  logic Busy;
  logic Overflow;

  always #5 Clk = ~Clk;

  pulse_stretcher #(
    .HOLD_CYCLES (4),
    .GAP_CYCLES  (2),
    .PEND_DEPTH  (2)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .PulseIn  (PulseIn),
    .LevelOut (LevelOut),
    .Busy     (Busy),
    .Overflow (Overflow)
  );

  typedef struct {
    int   edge_n;
    logic lvl;
    logic busy;
    logic ovf;
  } exp_t;

  exp_t  exp_q[$];
  int    pulses[$];
  int    lw_s[$];
  int    lw_e[$];
  int    bw_s[$];
  int    bw_e[$];
  int    ovf_at;
  int    rst_at;
  int    e;
  int    errors = 0;
  int    checks = 0;
  string sc;

  task automatic check1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s/%s @edge %0d: observed=%b expected=%b", sc, tag, e, obs, expv);
    end
  endtask

  function automatic logic in_pairs(input int x, input int s[$], input int en[$]);
    for (int i = 0; i < s.size(); i++) begin
      if (x >= s[i] && x <= en[i]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic push_expect(input int lo, input int hi);
    exp_t t;
    for (int x = lo; x <= hi; x++) begin
      t.edge_n = x;
      t.lvl    = !in_pairs(x, lw_s, lw_e);
      t.busy   = in_pairs(x, bw_s, bw_e);
      t.ovf    = (x == ovf_at);
      exp_q.push_back(t);
    end
  endtask

  task automatic clear_cfg(input string name);
    sc = name;
    pulses.delete();
    lw_s.delete(); lw_e.delete();
    bw_s.delete(); bw_e.delete();
    ovf_at = -1;
    rst_at = -1;
  endtask

  task automatic do_reset();
    Reset   = 1'b1;
    PulseIn = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    e     = 0;
  endtask

  task automatic do_edge();
    exp_t t;
    logic p;
    p = 1'b0;
    foreach (pulses[i]) begin
      if (pulses[i] == e + 1) p = 1'b1;
    end
    PulseIn = p;
    Reset   = (e + 1 == rst_at);
    @(posedge Clk);
    #1;
    e++;
    while (exp_q.size() > 0 && exp_q[0].edge_n == e) begin
      t = exp_q.pop_front();
      check1("LevelOut", LevelOut, t.lvl);
      check1("Busy", Busy, t.busy);
      check1("Overflow", Overflow, t.ovf);
    end
  endtask

  task automatic run(input int last);
    while (e < last) do_edge();
    PulseIn = 1'b0;
    Reset   = 1'b0;
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL %s/leftover: observed=%0d unchecked entries expected=0", sc, exp_q.size());
    end
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    Reset   = 1'b1;
    PulseIn = 1'b0;
    e       = 0;

    // Reset state
    clear_cfg("reset");
    do_reset();
    check1("LevelOut", LevelOut, 1'b1);
    check1("Busy", Busy, 1'b0);
    check1("Overflow", Overflow, 1'b0);

    // Single pulse at edge 10
    clear_cfg("single");
    pulses = '{10};
    lw_s = '{10}; lw_e = '{13};
    bw_s = '{10}; bw_e = '{15};
    push_expect(9, 17);
    do_reset();
    run(18);

    // Pulses at 10..13: windows 10,16,22; fourth dropped
    clear_cfg("burst");
    pulses = '{10, 11, 12, 13};
    lw_s = '{10, 16, 22}; lw_e = '{13, 19, 25};
    bw_s = '{10}; bw_e = '{27};
    ovf_at = 13;
    push_expect(9, 29);
    do_reset();
    run(30);

    // Second pulse coincident with the gap-end edge: no idle cycle
    clear_cfg("gapend");
    pulses = '{10, 16};
    lw_s = '{10, 16}; lw_e = '{13, 19};
    bw_s = '{10}; bw_e = '{21};
    push_expect(9, 23);
    do_reset();
    run(24);

    // Queue full plus pulse on gap-end edge: accepted, no overflow
    clear_cfg("fullgap");
    pulses = '{10, 11, 12, 16};
    lw_s = '{10, 16, 22, 28}; lw_e = '{13, 19, 25, 31};
    bw_s = '{10}; bw_e = '{33};
    push_expect(9, 35);
    do_reset();
    run(36);

    // Reset mid-window with one queued event, then a fresh pulse at 20
    clear_cfg("midreset");
    pulses = '{10, 11, 20};
    rst_at = 12;
    lw_s = '{10, 20}; lw_e = '{11, 23};
    bw_s = '{10, 20}; bw_e = '{11, 25};
    push_expect(9, 27);
    do_reset();
    run(28);

    // PulseIn held high three cycles from idle
    clear_cfg("held");
    pulses = '{10, 11, 12};
    lw_s = '{10, 16, 22}; lw_e = '{13, 19, 25};
    bw_s = '{10}; bw_e = '{27};
    push_expect(9, 29);
    do_reset();
    run(30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
